ccff_loader: RTL and testbench



---
 rtl/ccff_loader_pkg.sv | 18 +
 rtl/ccff_loader_if.sv | 25 ++
 rtl/ccff_rb_packer.sv | 85 ++++++++
 rtl/ccff_loader.sv | 119 +++++++++++
 tb/tb_ccff_loader.sv | 186 ++++++++++++++++++
 5 files changed

// File: rtl/ccff_loader_pkg.sv
// ccff_loader_pkg
// Shared definitions for the configuration-chain loader:
//   state_t   - loader FSM states (IDLE, LOAD, DRAIN)
//   words_for - number of W-bit words needed to carry a chain_len-bit stream
package ccff_loader_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    function automatic int unsigned words_for(input int unsigned chain_len,
                                              input int unsigned w);
        return (chain_len + w - 1) / w;
    endfunction

endpackage

// File: rtl/ccff_loader_if.sv
// ccff_loader_if
// Word-stream bus between the tile programming interface and the loader.
//   in_data/in_valid/in_ready    : bitstream words toward the chain
//   out_data/out_valid/out_ready : readback words captured from ccff_tail
// master = programming side, slave = loader.
interface ccff_loader_if #(
    parameter int W = 8
);
    logic [W-1:0] in_data;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] out_data;
    logic         out_valid;
    logic         out_ready;

    modport master (
        output in_data, in_valid, out_ready,
        input  in_ready, out_data, out_valid
    );

    modport slave (
        input  in_data, in_valid, out_ready,
        output in_ready, out_data, out_valid
    );
endinterface

// File: rtl/ccff_rb_packer.sv
// ccff_rb_packer
// Readback deserializer: packs bits captured from ccff_tail LSB-first into
// W-bit words and presents them through a single holding register.
//   bit_vld/bit_in : captured bit, valid in cycles where the chain shifts
//   bit_last       : the captured bit is the final bit of the load
//   out_*          : readback word handshake
//   can_accept     : a bit may be captured this cycle
//   empty          : accumulator holds no bits (holding register not included)
module ccff_rb_packer
    import ccff_loader_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         prog_clk,
    input  logic         prog_reset_n,
    input  logic         bit_vld,
    input  logic         bit_in,
    input  logic         bit_last,
    input  logic         out_ready,
    output logic [W-1:0] out_data,
    output logic         out_valid,
    output logic         can_accept,
    output logic         empty
);
    localparam int NW = $clog2(W + 1);

    logic [W-1:0]  acc, acc_n;
    logic [NW-1:0] acc_cnt, cnt_n;
    logic          acc_full, full_n;
    logic [W-1:0]  data_n;
    logic          valid_n;
    logic          hold_free;

    // The holding register is free if empty or being read this cycle.
    assign hold_free  = !out_valid || out_ready;
    // A completed word parked in the accumulator blocks capture until it can move.
    assign can_accept = !acc_full || hold_free;
    assign empty      = !acc_full && (acc_cnt == NW'(0));

    always_comb begin
        acc_n   = acc;
        cnt_n   = acc_cnt;
        full_n  = acc_full;
        data_n  = out_data;
        valid_n = out_valid && !out_ready;
        // Parked word moves out first, so a new bit can start the next word.
        if (acc_full && hold_free) begin
            data_n  = acc;
            valid_n = 1'b1;
            acc_n   = '0;
            cnt_n   = '0;
            full_n  = 1'b0;
        end
        if (bit_vld) begin
            acc_n = acc_n | (W'(bit_in) << cnt_n);
            cnt_n = cnt_n + NW'(1);
            if (cnt_n == NW'(W) || bit_last) begin
                if (!valid_n) begin
                    data_n  = acc_n;
                    valid_n = 1'b1;
                    acc_n   = '0;
                    cnt_n   = '0;
                end else begin
                    full_n = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge prog_clk or negedge prog_reset_n) begin
        if (!prog_reset_n) begin
            acc       <= '0;
            acc_cnt   <= '0;
            acc_full  <= 1'b0;
            out_data  <= '0;
            out_valid <= 1'b0;
        end else begin
            acc       <= acc_n;
            acc_cnt   <= cnt_n;
            acc_full  <= full_n;
            out_data  <= data_n;
            out_valid <= valid_n;
        end
    end
endmodule

// File: rtl/ccff_loader.sv
// ccff_loader
// Serializes a word-stream bitstream onto a configuration chain (ccff_head)
// while capturing the previous contents from ccff_tail as readback words.
//   prog_clk, prog_reset_n : clock, async active-low reset
//   start                  : begins a load when idle
//   bus (slave)            : input bitstream and readback word handshakes
//   ccff_head / ccff_tail  : serial data into / out of the chain
//   ccff_clk_en            : chain shifts at the end of each cycle it is high
//   busy, done, bit_cnt    : status (LOAD/DRAIN, completion pulse, bits shifted)
module ccff_loader
    import ccff_loader_pkg::*;
#(
    parameter int CHAIN_LEN = 20,
    parameter int W         = 8
) (
    input  logic                           prog_clk,
    input  logic                           prog_reset_n,
    input  logic                           start,
    ccff_loader_if.slave                   bus,
    output logic                           ccff_head,
    input  logic                           ccff_tail,
    output logic                           ccff_clk_en,
    output logic                           busy,
    output logic                           done,
    output logic [$clog2(CHAIN_LEN+1)-1:0] bit_cnt
);
    localparam int CW = $clog2(CHAIN_LEN + 1);
    localparam int NW = $clog2(W + 1);

    state_t        state, state_n;
    logic [W-1:0]  in_buf;
    logic [NW-1:0] in_cnt;
    logic [CW-1:0] acc_bits;   // bits accepted from the input stream so far
    logic [31:0]   rem_w;
    logic [NW-1:0] take;
    logic          shift, xfer, in_ready;
    logic          rb_can_accept, rb_empty, rb_valid;
    logic [W-1:0]  rb_data;
    logic          drain_done;

    assign shift = (state == ST_LOAD) && (in_cnt != NW'(0)) && rb_can_accept;

    // No further words are taken once the whole chain length has been accepted,
    // so the stream is not consumed past the end of the bitstream.
    assign in_ready = (state == ST_LOAD) && (acc_bits != CW'(CHAIN_LEN)) &&
                      ((in_cnt == NW'(0)) || ((in_cnt == NW'(1)) && shift));
    assign xfer     = bus.in_valid && in_ready;

    // Last word may carry fewer live bits than W; the rest are discarded.
    assign rem_w = 32'(CHAIN_LEN) - 32'(acc_bits);
    assign take  = (rem_w > 32'(W)) ? NW'(W) : NW'(rem_w);

    assign ccff_clk_en  = shift;
    assign ccff_head    = shift & in_buf[0];
    assign busy         = (state != ST_IDLE);
    assign bus.in_ready = in_ready;
    assign bus.out_data = rb_data;
    assign bus.out_valid = rb_valid;
    assign drain_done   = rb_empty && (!rb_valid || bus.out_ready);

    ccff_rb_packer #(.W(W)) u_rb_packer (
        .prog_clk     (prog_clk),
        .prog_reset_n (prog_reset_n),
        .bit_vld      (shift),
        .bit_in       (ccff_tail),
        .bit_last     (bit_cnt == CW'(CHAIN_LEN - 1)),
        .out_ready    (bus.out_ready),
        .out_data     (rb_data),
        .out_valid    (rb_valid),
        .can_accept   (rb_can_accept),
        .empty        (rb_empty)
    );

    always_ff @(posedge prog_clk or negedge prog_reset_n) begin
        if (!prog_reset_n) state <= ST_IDLE;
        else               state <= state_n;
    end

    always_comb begin
        state_n = state;
        done    = 1'b0;
        case (state)
            ST_IDLE:  if (start) state_n = ST_LOAD;
            ST_LOAD:  if (bit_cnt == CW'(CHAIN_LEN)) state_n = ST_DRAIN;
            ST_DRAIN: begin
                if (drain_done) begin
                    done    = 1'b1;
                    state_n = ST_IDLE;
                end
            end
            default:  state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge prog_clk or negedge prog_reset_n) begin
        if (!prog_reset_n) begin
            in_buf   <= '0;
            in_cnt   <= '0;
            acc_bits <= '0;
            bit_cnt  <= '0;
        end else if (state == ST_IDLE && start) begin
            in_cnt   <= '0;
            acc_bits <= '0;
            bit_cnt  <= '0;
        end else begin
            if (shift) bit_cnt <= bit_cnt + CW'(1);
            // A word taken in the same cycle as the last buffered bit shifts
            // replaces the buffer outright.
            if (xfer) begin
                in_buf   <= bus.in_data;
                in_cnt   <= take;
                acc_bits <= acc_bits + CW'(take);
            end else if (shift) begin
                in_buf <= in_buf >> 1;
                in_cnt <= in_cnt - NW'(1);
            end
        end
    end
endmodule

// File: tb/tb_ccff_loader.sv
// tb_ccff_loader
// Directed bench for ccff_loader with a behavioral 20-flop chain model.
module tb_ccff_loader;
    import ccff_loader_pkg::*;

    localparam int CL = 20;

    logic        prog_clk;
    logic        prog_reset_n;
    logic        start;
    logic        ccff_head;
    logic        ccff_tail;
    logic        ccff_clk_en;
    logic        busy;
    logic        done;
    logic [4:0]  bit_cnt;
    logic [CL-1:0] chain = '0;

    int total = 0;
    int bad   = 0;

    logic [7:0] rb [8];
    int rb_n, en_cnt, en_stall, done_cyc, bc_probe, stable_err;

    ccff_loader_if #(.W(8)) bus ();

    ccff_loader #(.CHAIN_LEN(CL), .W(8)) dut (
        .prog_clk     (prog_clk),
        .prog_reset_n (prog_reset_n),
        .start        (start),
        .bus          (bus),
        .ccff_head    (ccff_head),
        .ccff_tail    (ccff_tail),
        .ccff_clk_en  (ccff_clk_en),
        .busy         (busy),
        .done         (done),
        .bit_cnt      (bit_cnt)
    );

    initial prog_clk = 1'b0;
    always #5 prog_clk = ~prog_clk;

    // Chain model: head enters at the top, the first bit ends at index 0 (tail).
    always @(posedge prog_clk) if (ccff_clk_en) chain <= {ccff_head, chain[CL-1:1]};
    assign ccff_tail = chain[0];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_in_ready"},  32'(bus.in_ready), 32'd0);
        chk({tag, "_out_valid"}, 32'(bus.out_valid), 32'd0);
        chk({tag, "_out_data"},  32'(bus.out_data), 32'd0);
        chk({tag, "_head"},      32'(ccff_head), 32'd0);
        chk({tag, "_clk_en"},    32'(ccff_clk_en), 32'd0);
        chk({tag, "_busy"},      32'(busy), 32'd0);
        chk({tag, "_done"},      32'(done), 32'd0);
        chk({tag, "_bit_cnt"},   32'(bit_cnt), 32'd0);
    endtask

    // Cycle 0 carries the start pulse; windows are given in those cycle numbers.
    task automatic run_load(input logic [7:0] w0, input logic [7:0] w1, input logic [7:0] w2,
                            input int stall_at, input int stall_len,
                            input int gap_at, input int gap_len,
                            input int start2_at, input int rst_at);
        logic [7:0] words [3];
        int widx, cyc;
        logic prev_hold;
        logic [7:0] prev_data;
        bit fin;
        words[0] = w0; words[1] = w1; words[2] = w2;
        widx = 0; rb_n = 0; en_cnt = 0; en_stall = 0; done_cyc = -1;
        bc_probe = -1; stable_err = 0; prev_hold = 1'b0; prev_data = '0; fin = 1'b0;
        @(negedge prog_clk);
        cyc = 0;
        start = 1'b1;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 200 && !fin; i++) begin
            @(negedge prog_clk);
            cyc++;
            start         = (cyc == start2_at);
            bus.out_ready = !(cyc >= stall_at && cyc < stall_at + stall_len);
            bus.in_valid  = (widx < 3) && !(cyc >= gap_at && cyc < gap_at + gap_len);
            bus.in_data   = (widx < 3) ? words[widx] : 8'h00;
            if (cyc == rst_at) begin
                chk("rst_bc_before", 32'(bit_cnt), 32'd9);
                prog_reset_n = 1'b0;
                #1;
                chk_reset_vals("rst_mid");
                fin = 1'b1;
            end else begin
                #1;
                if (prev_hold && (!bus.out_valid || bus.out_data !== prev_data)) stable_err++;
                prev_hold = bus.out_valid && !bus.out_ready;
                prev_data = bus.out_data;
                if (ccff_clk_en) begin
                    en_cnt++;
                    if (cyc >= stall_at && cyc < stall_at + stall_len) en_stall++;
                end
                if (bus.out_valid && bus.out_ready && rb_n < 8) begin
                    rb[rb_n] = bus.out_data;
                    rb_n++;
                end
                if (bus.in_valid && bus.in_ready) widx++;
                if (cyc == start2_at + 1) bc_probe = int'(bit_cnt);
                if (done) begin
                    done_cyc = cyc;
                    fin = 1'b1;
                end
            end
        end
        start = 1'b0;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
    endtask

    task automatic chk_load(input string tag, input logic [CL-1:0] exp_chain,
                            input logic [7:0] r0, input logic [7:0] r1, input logic [7:0] r2,
                            input int exp_done);
        chk({tag, "_done_cyc"}, 32'(done_cyc), 32'(exp_done));
        chk({tag, "_clk_en_cnt"}, 32'(en_cnt), 32'd20);
        chk({tag, "_chain"}, 32'(chain), 32'(exp_chain));
        chk({tag, "_rb_words"}, 32'(rb_n), 32'(words_for(CL, 8)));
        chk({tag, "_rb0"}, 32'(rb[0]), 32'(r0));
        chk({tag, "_rb1"}, 32'(rb[1]), 32'(r1));
        chk({tag, "_rb2"}, 32'(rb[2]), 32'(r2));
        chk({tag, "_rb_stable"}, 32'(stable_err), 32'd0);
        chk({tag, "_bit_cnt"}, 32'(bit_cnt), 32'd20);
        @(negedge prog_clk);
        chk({tag, "_busy_after"}, 32'(busy), 32'd0);
        chk({tag, "_done_after"}, 32'(done), 32'd0);
    endtask

    initial begin
        prog_reset_n  = 1'b0;
        start         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b1;
        #12;
        chk_reset_vals("por");
        @(negedge prog_clk);
        prog_reset_n = 1'b1;
        @(negedge prog_clk);

        // Plain load into an all-zero chain.
        run_load(8'hA5, 8'h3C, 8'h0F, -1, 0, -1, 0, -1, -1);
        chk_load("load1", 20'hF3CA5, 8'h00, 8'h00, 8'h00, 23);

        // Reload reads back the previous bitstream.
        run_load(8'hFF, 8'hFF, 8'hFF, -1, 0, -1, 0, -1, -1);
        chk_load("load2", 20'hFFFFF, 8'hA5, 8'h3C, 8'h0F, 23);

        // Readback backpressure in cycles 10..24: shifting stops from cycle 18.
        run_load(8'hA5, 8'h3C, 8'h0F, 10, 15, -1, 0, -1, -1);
        chk_load("stall", 20'hF3CA5, 8'hFF, 8'hFF, 8'h0F, 30);
        chk("stall_en_in_window", 32'(en_stall), 32'd8);

        // Input gap in cycles 9..13 costs exactly 5 cycles.
        run_load(8'h12, 8'h34, 8'h56, -1, 0, 9, 5, -1, -1);
        chk_load("gap", 20'h63412, 8'hA5, 8'h3C, 8'h0F, 28);

        // Start while busy is ignored.
        run_load(8'h5A, 8'hC3, 8'h99, -1, 0, -1, 0, 12, -1);
        chk_load("restart", 20'h9C35A, 8'h12, 8'h34, 8'h06, 23);
        chk("restart_bc_probe", 32'(bc_probe), 32'd11);

        // Reset after 9 bits, then a fresh load.
        run_load(8'hDE, 8'hAD, 8'hBE, -1, 0, -1, 0, -1, 11);
        @(negedge prog_clk);
        chk_reset_vals("rst_held");
        prog_reset_n = 1'b1;
        @(negedge prog_clk);
        run_load(8'h21, 8'h43, 8'h65, -1, 0, -1, 0, -1, -1);
        chk_load("after_rst", 20'h54321, 8'hE1, 8'hF4, 8'h0E, 23);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
